// File: rtl/tick_pkg.sv
// Shared types and 7-segment constants for the tick BCD counter.
// Segment bit order: bit0=a ... bit6=g, active high.
package tick_pkg;

    typedef logic [3:0] count_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment decoder.
// Codes above 9 show a blank display.
module seg7_decode
    import tick_pkg::*;
(
    input  count_t     i_digit,
    output logic [6:0] o_seg
);

    // Map each digit to its segment pattern
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Up/down BCD counter advanced by rising edges of an async tick.
// Optional macro TICK_DEBOUNCE_EN adds a 3-sample majority filter.
module tick_bcd_counter
    import tick_pkg::*;
#(
    parameter int MAX_COUNT = 9
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam count_t L_MAX = count_t'(MAX_COUNT);

    logic       w_clk;
    logic       w_rst_n;
    logic       w_tick;
    logic       w_cnt_en;
    logic       w_up;
    logic       w_clr;
    logic [1:0] w_unused;
    logic       w_level;
    logic       w_edge;
    logic [6:0] w_seg;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level_d;
    count_t     r_count;
    logic       r_wrap;

    assign w_clk    = io_in[0];
    assign w_rst_n  = io_in[1];
    assign w_tick   = io_in[2];
    assign w_cnt_en = io_in[3];
    assign w_up     = io_in[4];
    assign w_clr    = io_in[5];
    assign w_unused = io_in[7:6];

    // Two-flop synchronizer for the tick, plus the delayed level for edge detect
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync1   <= w_tick;
            r_sync2   <= r_sync1;
            r_level_d <= w_level;
        end
    end

`ifdef TICK_DEBOUNCE_EN
    logic r_f0;
    logic r_f1;
    logic r_filt;

    // Majority vote over three consecutive synchronized samples
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_f0   <= 1'b0;
            r_f1   <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_f0   <= r_sync2;
            r_f1   <= r_f0;
            r_filt <= (r_sync2 & r_f0) | (r_sync2 & r_f1) | (r_f0 & r_f1);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign w_edge = w_level & ~r_level_d;

    // Count register with wrap pulse; clear beats any edge
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_clr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_edge && w_cnt_en) begin
            if (w_up) begin
                if (r_count == L_MAX) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + 4'd1;
                    r_wrap  <= 1'b0;
                end
            end else begin
                if (r_count == 4'd0) begin
                    r_count <= L_MAX;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count - 4'd1;
                    r_wrap  <= 1'b0;
                end
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    seg7_decode u_seg (
        .i_digit (r_count),
        .o_seg   (w_seg)
    );

    assign io_out = {r_wrap, w_seg};

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Randomized bench for tick_bcd_counter with an event-queue reference model.
// Directed scenarios first, then random pulse trains.
module tb_tick_bcd_counter;

`ifdef TICK_DEBOUNCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif
    localparam int MAXC = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       cnt_en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clr = 1'b0;
    logic [1:0] junk = 2'b00;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int wraps = 0;

    int m_cnt = 0;
    bit m_wrap = 1'b0;
    bit h_prev = 1'b0;
    int due_q[$];

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    assign io_in = {junk, clr, up_dn, cnt_en, tick, rst_n, clk};

    tick_bcd_counter #(.MAX_COUNT(MAXC)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: a tick rise first sampled at cycle k takes effect at k+LAT-1
    task automatic model();
        bit h;
        bit hit;
        h = rst_n ? tick : 1'b0;
        if (h && !h_prev) due_q.push_back(cyc + LAT - 1);
        h_prev = h;
        if (!rst_n) begin
            due_q.delete();
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else begin
            hit = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                hit = 1'b1;
                void'(due_q.pop_front());
            end
            m_wrap = 1'b0;
            if (clr) begin
                m_cnt = 0;
            end else if (hit && cnt_en) begin
                if (up_dn) begin
                    if (m_cnt == MAXC) begin
                        m_cnt  = 0;
                        m_wrap = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        m_cnt  = MAXC;
                        m_wrap = 1'b1;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model();
        #1;
        chk("seg", {1'b0, io_out[6:0]}, {1'b0, seg_tab[m_cnt]});
        chk("wrap", {7'b0, io_out[7]}, {7'b0, m_wrap});
        if (io_out[7]) wraps++;
        junk = 2'($urandom);
    endtask

    task automatic pulse(input int hi, input int lo);
        tick = 1'b1;
        repeat (hi) step();
        tick = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_reset();
        tick  = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int hi;
        int lo;
        // reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_seg", {1'b0, io_out[6:0]}, 8'h3F);
        chk("rst_wrap", {7'b0, io_out[7]}, 8'h00);
        rst_n = 1'b1;
        step();

        // three pulses up
        cnt_en = 1'b1;
        up_dn  = 1'b1;
        wraps  = 0;
        repeat (3) pulse(4, 4);
        chk("up3_seg", {1'b0, io_out[6:0]}, 8'h4F);
        chk("up3_wraps", 8'(wraps), 8'd0);

        // ten pulses up wraps to 0
        do_reset();
        wraps = 0;
        repeat (9) pulse(4, 4);
        chk("up9_seg", {1'b0, io_out[6:0]}, 8'h6F);
        tick = 1'b1;
        repeat (LAT - 1) step();
        chk("up10_pre", {7'b0, io_out[7]}, 8'h00);
        step();
        chk("up10_wrap", {7'b0, io_out[7]}, 8'h01);
        chk("up10_seg", {1'b0, io_out[6:0]}, 8'h3F);
        step();
        chk("up10_wrap_off", {7'b0, io_out[7]}, 8'h00);
        tick = 1'b0;
        repeat (4) step();
        chk("up10_wraps", 8'(wraps), 8'd1);

        // one pulse down from 0
        do_reset();
        wraps = 0;
        up_dn = 1'b0;
        pulse(4, 4);
        chk("dn1_seg", {1'b0, io_out[6:0]}, 8'h6F);
        chk("dn1_wraps", 8'(wraps), 8'd1);

        // clear on the edge cycle at count 5
        do_reset();
        up_dn = 1'b1;
        repeat (5) pulse(4, 4);
        chk("clr_pre", {1'b0, io_out[6:0]}, 8'h6D);
        tick = 1'b1;
        repeat (LAT - 1) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_seg", {1'b0, io_out[6:0]}, 8'h3F);
        chk("clr_wrap", {7'b0, io_out[7]}, 8'h00);
        repeat (2) step();
        tick = 1'b0;
        repeat (4) step();
        chk("clr_hold", {1'b0, io_out[6:0]}, 8'h3F);

        // disabled edges are dropped
        do_reset();
        cnt_en = 1'b0;
        repeat (2) pulse(4, 4);
        chk("dis_seg", {1'b0, io_out[6:0]}, 8'h3F);
        cnt_en = 1'b1;
        tick = 1'b1;
        repeat (LAT - 1) step();
        chk("lat_early", {1'b0, io_out[6:0]}, 8'h3F);
        step();
        chk("lat_hit", {1'b0, io_out[6:0]}, 8'h06);
        tick = 1'b0;
        repeat (4) step();
        chk("lat_once", {1'b0, io_out[6:0]}, 8'h06);

        // reset mid-count with tick high
        do_reset();
        repeat (7) pulse(4, 4);
        chk("mid_pre", {1'b0, io_out[6:0]}, 8'h07);
        tick = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst", {1'b0, io_out[6:0]}, 8'h3F);
        repeat (LAT) step();
        chk("mid_one", {1'b0, io_out[6:0]}, 8'h06);
        tick = 1'b0;
        repeat (4) step();
        chk("mid_hold", {1'b0, io_out[6:0]}, 8'h06);

        // random pulse trains
        for (int p = 0; p < 250; p++) begin
            up_dn = 1'($urandom);
            hi = $urandom_range(4, 7);
            lo = $urandom_range(4, 7);
            tick = 1'b1;
            for (int i = 0; i < hi; i++) begin
                cnt_en = ($urandom % 4) != 0;
                clr    = ($urandom % 20) == 0;
                step();
            end
            tick = 1'b0;
            for (int i = 0; i < lo; i++) begin
                cnt_en = ($urandom % 4) != 0;
                clr    = ($urandom % 20) == 0;
                rst_n  = !(i == 0 && ($urandom % 12) == 0);
                step();
            end
            rst_n = 1'b1;
        end
        clr = 1'b0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
